// File: rtl/lcd_spi_sink.sv
// Receive side of the LCD 4-wire SPI link: deserialises {dc,byte} words, tracks the
// CASET/RASET window and turns RAMWR data into addressed RGB565 pixel writes.
module lcd_spi_sink #(
  parameter int H_RES       = 240,
  parameter int V_RES       = 320,
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk_50MHz,
  input  logic        sys_rst_n,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  output logic        byte_valid,
  output logic [8:0]  byte_data,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        frag_err
);
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {S_CMD, S_CASET, S_RASET, S_RAMWR, S_SKIP} state_t;

  logic [SS-1:0] cs_sync, sclk_sync, mosi_sync, dc_sync;
  logic          cs_s, sclk_s, mosi_s, dc_s, sclk_d, cs_d, sample;
  logic [2:0]    cnt;
  logic [6:0]    sh;
  logic          done;
  logic [8:0]    word;

  assign cs_s   = cs_sync[SS-1];
  assign sclk_s = sclk_sync[SS-1];
  assign mosi_s = mosi_sync[SS-1];
  assign dc_s   = dc_sync[SS-1];
  // An edge seen on the same cycle cs rises still counts: cs was low a cycle earlier.
  assign sample = sclk_s & ~sclk_d & (~cs_s | ~cs_d);

  always_ff @(posedge sys_clk_50MHz) begin
    if (!sys_rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SS-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SS-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SS-2:0], spi_mosi};
      dc_sync   <= {dc_sync[SS-2:0], spi_dc};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      sh         <= '0;
      done       <= 1'b0;
      word       <= '0;
      frag_err   <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      done       <= 1'b0;
      frag_err   <= 1'b0;
      byte_valid <= done;
      if (done) byte_data <= word;
      if (sample) begin
        sh <= {sh[5:0], mosi_s};
        if (cnt == 3'd7) begin
          done <= 1'b1;
          word <= {dc_s, sh, mosi_s};
          cnt  <= '0;
        end else if (cs_s) begin
          cnt      <= '0;
          frag_err <= 1'b1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end else if (cs_s) begin
        cnt      <= '0;
        frag_err <= (cnt != 3'd0);
      end
    end
  end

  state_t     state, state_n;
  logic [1:0] pcnt;
  logic       p_sh, p_eh;
  logic [7:0] p_sl, hi;
  logic       phase_lo;
  logic [8:0] xs, xe, ys, ye, x, y;
  logic       is_cmd, is_par, ld_x, ld_y, pix_fire, ram_start, x_end, y_end;

  always_ff @(posedge sys_clk_50MHz) begin
    if (!sys_rst_n) state <= S_CMD;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (byte_valid) begin
      if (!byte_data[8]) begin
        case (byte_data[7:0])
          8'h2A:   state_n = S_CASET;
          8'h2B:   state_n = S_RASET;
          8'h2C:   state_n = S_RAMWR;
          default: state_n = S_SKIP;
        endcase
      end else if ((state == S_CASET || state == S_RASET) && pcnt == 2'd3) begin
        state_n = S_CMD;
      end
    end
  end

  always_comb begin
    is_cmd    = byte_valid & ~byte_data[8];
    is_par    = byte_valid & byte_data[8];
    ld_x      = is_par && state == S_CASET && pcnt == 2'd3;
    ld_y      = is_par && state == S_RASET && pcnt == 2'd3;
    pix_fire  = is_par && state == S_RAMWR && phase_lo;
    ram_start = is_cmd && byte_data[7:0] == 8'h2C;
    // An inverted window collapses that axis to its start value.
    x_end     = (xs > xe) || (x == xe);
    y_end     = (ys > ye) || (y == ye);
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (!sys_rst_n) begin
      pcnt       <= '0;
      p_sh       <= 1'b0;
      p_sl       <= '0;
      p_eh       <= 1'b0;
      hi         <= '0;
      phase_lo   <= 1'b0;
      xs         <= '0;
      xe         <= 9'(H_RES - 1);
      ys         <= '0;
      ye         <= 9'(V_RES - 1);
      x          <= '0;
      y          <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= pix_fire;
      frame_done <= pix_fire & x_end & y_end;
      if (is_cmd) begin
        pcnt     <= '0;
        phase_lo <= 1'b0;
      end else if (is_par && (state == S_CASET || state == S_RASET)) begin
        pcnt <= pcnt + 2'd1;
        case (pcnt)
          2'd0:    p_sh <= byte_data[0];
          2'd1:    p_sl <= byte_data[7:0];
          2'd2:    p_eh <= byte_data[0];
          default: ;
        endcase
      end else if (is_par && state == S_RAMWR) begin
        phase_lo <= ~phase_lo;
        if (!phase_lo) hi <= byte_data[7:0];
      end
      if (ld_x) begin
        xs <= {p_sh, p_sl};
        xe <= {p_eh, byte_data[7:0]};
      end
      if (ld_y) begin
        ys <= {p_sh, p_sl};
        ye <= {p_eh, byte_data[7:0]};
      end
      if (ram_start) begin
        x <= xs;
        y <= ys;
      end else if (pix_fire) begin
        pix_x    <= x;
        pix_y    <= y;
        pix_data <= {hi, byte_data[7:0]};
        if (!x_end) begin
          x <= x + 9'd1;
        end else begin
          x <= xs;
          y <= y_end ? ys : y + 9'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_spi_sink.sv
// Bench for lcd_spi_sink: drives SPI words, predicts pixels from window/index arithmetic.
module tb_lcd_spi_sink;
  localparam int H = 8, V = 6, SS = 2, HALF = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cs = 1'b1, sclk = 1'b0, mosi = 1'b0, dc = 1'b0;
  logic        byte_valid, pix_valid, frame_done, frag_err;
  logic [8:0]  byte_data, pix_x, pix_y;
  logic [15:0] pix_data;

  lcd_spi_sink #(.H_RES(H), .V_RES(V), .SYNC_STAGES(SS)) dut (
    .sys_clk_50MHz(clk), .sys_rst_n(rst_n), .spi_cs(cs), .spi_sclk(sclk),
    .spi_mosi(mosi), .spi_dc(dc), .byte_valid(byte_valid), .byte_data(byte_data),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_done(frame_done), .frag_err(frag_err));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, rise_cyc = 0, last_bv_cyc = 0, frag_cnt = 0;
  logic prev_bv = 1'b0;
  logic [8:0]  rx_bytes[$], exp_bytes[$];
  logic [34:0] rx_pix[$], exp_pix[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_valid) begin
      last_bv_cyc = cyc;
      rx_bytes.push_back(byte_data);
    end
    if (pix_valid) begin
      rx_pix.push_back({frame_done, pix_x, pix_y, pix_data});
      chk("pix_latency", prev_bv, 1'b1);
    end
    if (frag_err) frag_cnt++;
    prev_bv = byte_valid;
  end

  // ---------------- reference model ----------------
  int m_mode;   // 0 cmd, 1 caset, 2 raset, 3 ramwr, 4 skip
  logic [7:0] m_par[$];
  logic [8:0] m_xs, m_xe, m_ys, m_ye;
  int m_n;
  bit m_have_hi;
  logic [7:0] m_hi;

  task automatic model_reset();
    m_mode = 0; m_par.delete(); m_xs = 0; m_xe = 9'(H-1); m_ys = 0; m_ye = 9'(V-1);
    m_n = 0; m_have_hi = 0; m_hi = 0;
  endtask

  task automatic model_word(input logic [8:0] w);
    int wd, ht, k;
    logic [8:0] s, e;
    if (!w[8]) begin
      m_par.delete(); m_have_hi = 0; m_n = 0;
      case (w[7:0])
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: m_mode = 3;
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par.push_back(w[7:0]);
      if (m_par.size() == 4) begin
        s = {m_par[0][0], m_par[1]};
        e = {m_par[2][0], m_par[3]};
        if (m_mode == 1) begin m_xs = s; m_xe = e; end
        else begin m_ys = s; m_ye = e; end
        m_par.delete(); m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_have_hi) begin
        m_hi = w[7:0]; m_have_hi = 1;
      end else begin
        wd = (m_xs > m_xe) ? 1 : int'(m_xe) - int'(m_xs) + 1;
        ht = (m_ys > m_ye) ? 1 : int'(m_ye) - int'(m_ys) + 1;
        k  = m_n % (wd * ht);
        exp_pix.push_back({(k == wd*ht - 1), 9'(int'(m_xs) + k % wd),
                           9'(int'(m_ys) + k / wd), m_hi, w[7:0]});
        m_n++; m_have_hi = 0;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [8:0] w, input bit cs_last = 1'b0);
    cs = 1'b0; dc = w[8];
    for (int i = 7; i >= 0; i--) begin
      mosi = w[i]; sclk = 1'b0;
      repeat (HALF) tick();
      sclk = 1'b1;
      if (i == 0) begin
        rise_cyc = cyc;
        if (cs_last) cs = 1'b1;
      end
      repeat (HALF) tick();
    end
    sclk = 1'b0;
    exp_bytes.push_back(w);
    model_word(w);
  endtask

  task automatic cs_idle();
    cs = 1'b1; repeat (HALF) tick();
  endtask

  task automatic send_pixels(input int n);
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      p = 16'($urandom);
      send_byte({1'b1, p[15:8]});
      send_byte({1'b1, p[7:0]});
    end
  endtask

  task automatic send_range(input logic [7:0] cmd, input logic [8:0] s, input logic [8:0] e);
    send_byte({1'b0, cmd});
    send_byte({1'b1, 7'($urandom_range(0, 127)), s[8]});
    send_byte({1'b1, s[7:0]});
    send_byte({1'b1, 7'($urandom_range(0, 127)), e[8]});
    send_byte({1'b1, e[7:0]});
  endtask

  task automatic flush(input string tag);
    repeat (12) tick();
    chk({tag, " nbytes"}, rx_bytes.size(), exp_bytes.size());
    for (int i = 0; i < rx_bytes.size() && i < exp_bytes.size(); i++)
      chk({tag, " byte"}, rx_bytes[i], exp_bytes[i]);
    chk({tag, " npix"}, rx_pix.size(), exp_pix.size());
    for (int i = 0; i < rx_pix.size() && i < exp_pix.size(); i++)
      chk({tag, " pix{fd,x,y,d}"}, rx_pix[i], exp_pix[i]);
    rx_bytes.delete(); exp_bytes.delete(); rx_pix.delete(); exp_pix.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; cs = 1'b1; sclk = 1'b0;
    repeat (n) tick();
    chk("reset outputs", {byte_valid, byte_data, pix_valid, pix_x, pix_y, pix_data, frame_done, frag_err}, '0);
    rst_n = 1'b1;
    model_reset();
    repeat (4) tick();
    rx_bytes.delete(); exp_bytes.delete(); rx_pix.delete(); exp_pix.delete();
  endtask

  typedef struct {
    logic [8:0] xs, xe, ys, ye;
    int         npix;
    logic [8:0] lx, ly;
    int         fds;
  } win_vec_t;

  win_vec_t tbl[5];

  initial begin
    int f0, fdc;
    tbl[0] = '{xs: 10,  xe: 11,  ys: 5,   ye: 6,   npix: 5, lx: 10,  ly: 5,   fds: 1};
    tbl[1] = '{xs: 5,   xe: 3,   ys: 0,   ye: 2,   npix: 4, lx: 5,   ly: 0,   fds: 1};
    tbl[2] = '{xs: 0,   xe: 2,   ys: 7,   ye: 1,   npix: 4, lx: 0,   ly: 7,   fds: 1};
    tbl[3] = '{xs: 9,   xe: 8,   ys: 4,   ye: 3,   npix: 3, lx: 9,   ly: 4,   fds: 3};
    tbl[4] = '{xs: 300, xe: 300, ys: 400, ye: 400, npix: 2, lx: 300, ly: 400, fds: 2};

    do_reset(3);

    // basic RAMWR at the default window, with byte latency check
    send_byte(9'h02C);
    repeat (8) tick();
    chk("byte latency", last_bv_cyc - rise_cyc, SS + 2);
    send_byte(9'h1F8); send_byte(9'h100); send_byte(9'h107); send_byte(9'h1E0);
    chk("t1 first pixel", exp_pix.size() > 0 ? exp_pix[0] : 35'h0, {1'b0, 9'd0, 9'd0, 16'hF800});
    flush("t1");

    foreach (tbl[i]) begin
      send_range(8'h2A, tbl[i].xs, tbl[i].xe);
      send_range(8'h2B, tbl[i].ys, tbl[i].ye);
      send_byte(9'h02C);
      send_pixels(tbl[i].npix);
      repeat (12) tick();
      fdc = 0;
      foreach (rx_pix[j]) fdc += int'(rx_pix[j][34]);
      chk($sformatf("win%0d last x", i), rx_pix.size() > 0 ? rx_pix[$][33:25] : 9'h1FF, tbl[i].lx);
      chk($sformatf("win%0d last y", i), rx_pix.size() > 0 ? rx_pix[$][24:16] : 9'h1FF, tbl[i].ly);
      chk($sformatf("win%0d frame_done count", i), fdc, tbl[i].fds);
      flush($sformatf("win%0d", i));
      cs_idle();
    end

    // full default-window frame
    do_reset(2);
    send_byte(9'h02C);
    send_pixels(H * V);
    repeat (12) tick();
    fdc = 0;
    foreach (rx_pix[j]) fdc += int'(rx_pix[j][34]);
    chk("frame done count", fdc, 1);
    chk("frame last pixel fd,x,y", rx_pix.size() > 0 ? rx_pix[$][34:16] : 19'h0, {1'b1, 9'(H-1), 9'(V-1)});
    flush("frame");
    cs_idle();

    // fragment: 5 bits then cs high
    f0 = frag_cnt;
    cs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = i[0]; sclk = 1'b0; repeat (HALF) tick();
      sclk = 1'b1; repeat (HALF) tick();
    end
    sclk = 1'b0; cs = 1'b1;
    repeat (12) tick();
    chk("frag_err pulses", frag_cnt - f0, 1);
    chk("frag no byte", rx_bytes.size(), 0);
    send_byte(9'h02C); send_byte(9'h1AB); send_byte(9'h1CD);
    flush("after frag");
    cs_idle();

    // cs rising together with the 8th edge
    f0 = frag_cnt;
    send_byte(9'h000, 1'b1);
    repeat (12) tick();
    chk("cs+8th edge frag", frag_cnt - f0, 0);
    flush("cs+8th edge");

    // RAMWR aborted after the hi byte
    send_byte(9'h02C); send_byte(9'h1AB);
    send_range(8'h2A, 9'd2, 9'd3);
    send_range(8'h2B, 9'd1, 9'd1);
    send_byte(9'h02C); send_byte(9'h111); send_byte(9'h122);
    flush("abort hi");

    // unknown command and stray data leave the window alone
    send_byte(9'h036); send_byte(9'h148);
    cs_idle();
    send_byte(9'h155); send_byte(9'h166);
    send_byte(9'h02C); send_byte(9'h177); send_byte(9'h188);
    flush("unknown cmd");

    // reset mid-pixel
    send_byte(9'h02C); send_byte(9'h1F8);
    flush("pre reset");
    do_reset(1);
    send_byte(9'h02C); send_byte(9'h112); send_byte(9'h134);
    flush("post reset");

    // randomized word stream
    for (int i = 0; i < 160; i++) begin
      int r;
      r = $urandom_range(0, 11);
      case (r)
        0: send_byte(9'h02A);
        1: send_byte(9'h02B);
        2, 3: send_byte(9'h02C);
        4: send_byte({1'b0, 8'($urandom)});
        default: send_byte({1'b1, 8'($urandom)});
      endcase
      if ($urandom_range(0, 7) == 0) cs_idle();
    end
    flush("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
